// File: rtl/native_bus_pkg.sv
// Shared types and constants for the native memory bus arbiter.
package native_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  // One native-bus request as presented by a master.
  typedef struct packed {
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] wstrb;
  } bus_req_t;

  // Read data handed back when the slave never answers.
  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter for an outstanding slave access. expired is high
// during the TIMEOUT-th enabled cycle, so the owner can terminate on it.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count;

  // Count enabled cycles; cleared by reset or whenever no access is pending.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 16'd1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/native_bus_arbiter.sv
// Two-master round-robin arbiter for the native memory bus. The grant is
// held for the whole transaction and a watchdog terminates accesses the
// slave never acknowledges.
module native_bus_arbiter
  import native_bus_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter int                 DATA_W       = 32,
  parameter int                 TIMEOUT      = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEFAULT)
) (
  input  logic                sys_clk_i,
  input  logic                rst_n,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                grant_o,
  output logic                timeout_o,
  output logic [7:0]          timeout_cnt_o
);

  state_t            state;
  logic              last_grant;
  logic              pick;
  logic              expired;
  logic [DATA_W-1:0] resp_data;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (sys_clk_i),
    .rst_n   (rst_n),
    .clr     (state != BUSY),
    .en      (state == BUSY),
    .expired (expired)
  );

  // Choose the master to serve: a lone requester wins, on contention the
  // one that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (m0_valid && m1_valid) begin
      pick = ~last_grant;
    end else if (m1_valid) begin
      pick = 1'b1;
    end
    resp_data = s_ready ? s_rdata : TIMEOUT_DATA;
  end

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_o       <= 1'b0;
      s_valid       <= 1'b0;
      s_addr        <= '0;
      s_wdata       <= '0;
      s_wstrb       <= '0;
      m0_ready      <= 1'b0;
      m0_rdata      <= '0;
      m1_ready      <= 1'b0;
      m1_rdata      <= '0;
      timeout_o     <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      // Response strobes and data live for the single RESP cycle only.
      m0_ready  <= 1'b0;
      m0_rdata  <= '0;
      m1_ready  <= 1'b0;
      m1_rdata  <= '0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_o <= pick;
            s_valid <= 1'b1;
            s_addr  <= pick ? m1_addr  : m0_addr;
            s_wdata <= pick ? m1_wdata : m0_wdata;
            s_wstrb <= pick ? m1_wstrb : m0_wstrb;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // An acknowledge on the expiry cycle still counts as a completion.
          if (s_ready || expired) begin
            s_valid <= 1'b0;
            state   <= RESP;
            if (grant_o) begin
              m1_ready <= 1'b1;
              m1_rdata <= resp_data;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= resp_data;
            end
            if (!s_ready) begin
              timeout_o <= 1'b1;
              if (timeout_cnt_o != 8'hFF) begin
                timeout_cnt_o <= timeout_cnt_o + 8'd1;
              end
            end
          end
        end
        RESP: begin
          last_grant <= grant_o;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_native_bus_arbiter.sv
// Directed self-checking bench for native_bus_arbiter (TIMEOUT = 8).
module tb_native_bus_arbiter;
  import native_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        grant_o, timeout_o;
  logic [7:0]  timeout_cnt_o;

  int checks = 0;
  int errors = 0;

  native_bus_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .TIMEOUT      (8),
    .TIMEOUT_DATA (32'hDEAD_BEEF)
  ) dut (
    .sys_clk_i     (clk),
    .rst_n         (rst_n),
    .m0_valid      (m0_valid),
    .m0_addr       (m0_addr),
    .m0_wdata      (m0_wdata),
    .m0_wstrb      (m0_wstrb),
    .m0_ready      (m0_ready),
    .m0_rdata      (m0_rdata),
    .m1_valid      (m1_valid),
    .m1_addr       (m1_addr),
    .m1_wdata      (m1_wdata),
    .m1_wstrb      (m1_wstrb),
    .m1_ready      (m1_ready),
    .m1_rdata      (m1_rdata),
    .s_valid       (s_valid),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_wstrb       (s_wstrb),
    .s_ready       (s_ready),
    .s_rdata       (s_rdata),
    .grant_o       (grant_o),
    .timeout_o     (timeout_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({s_valid, m0_ready, m1_ready, grant_o, timeout_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {s_valid, m0_ready, m1_ready, grant_o, timeout_o});
    end
    checks++;
    if ({m0_rdata, m1_rdata, s_addr, s_wdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {m0_rdata, m1_rdata, s_addr, s_wdata});
    end
    checks++;
    if ({s_wstrb, timeout_cnt_o} !== 12'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h want 0", {s_wstrb, timeout_cnt_o});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_m0_read();
    m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
    tick();
    checks++;
    if ({s_valid, s_addr, grant_o} !== {1'b1, 32'h0000_0010, 1'b0}) begin
      errors++;
      $display("FAIL rd_issue got v=%b a=%h g=%b want v=1 a=00000010 g=0", s_valid, s_addr, grant_o);
    end
    tick();
    checks++;
    if (m0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_early got %b want 0", m0_ready);
    end
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    checks++;
    if ({m0_ready, m0_rdata, m1_ready, m1_rdata, s_valid} !== {1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rd_resp got r0=%b d0=%h r1=%b d1=%h sv=%b want r0=1 d0=12345678 r1=0 d1=0 sv=0",
               m0_ready, m0_rdata, m1_ready, m1_rdata, s_valid);
    end
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();
    checks++;
    if ({m0_ready, m0_rdata, grant_o} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rd_after got r=%b d=%h g=%b want r=0 d=0 g=0", m0_ready, m0_rdata, grant_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h100;
    m1_valid = 1'b1; m1_addr = 32'h200;
    s_ready = 1'b1; s_rdata = 32'h5A5A_0001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_rdy = 2'b00;
      if (i % 3 == 2) exp_rdy = (((i - 2) / 3) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_ready, m0_ready} !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready cyc %0d got %b want %b", i, {m1_ready, m0_ready}, exp_rdy);
      end
      if (i % 3 == 1) begin
        checks++;
        if (grant_o !== 1'(((i - 1) / 3) % 2)) begin
          errors++;
          $display("FAIL rr_grant cyc %0d got %b want %0d", i, grant_o, ((i - 1) / 3) % 2);
        end
      end
    end
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    tick();
  endtask

  task automatic test_m1_write();
    bus_req_t req;
    req = '{addr: 32'h2000_0004, wdata: 32'h0000_0041, wstrb: 4'hF};
    m1_valid = 1'b1; m1_addr = req.addr; m1_wdata = req.wdata; m1_wstrb = req.wstrb;
    tick();
    m1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({s_valid, s_addr, s_wdata, s_wstrb, grant_o, m1_ready} !== {1'b1, req, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL wr_hold k=%0d got v=%b a=%h d=%h s=%h g=%b want v=1 a=20000004 d=00000041 s=f g=1",
                 k, s_valid, s_addr, s_wdata, s_wstrb, grant_o);
      end
      tick();
    end
    s_ready = 1'b1; s_rdata = 32'h0000_AAAA;
    tick();
    checks++;
    if ({m1_ready, m1_rdata, m0_ready} !== {1'b1, 32'h0000_AAAA, 1'b0}) begin
      errors++;
      $display("FAIL wr_resp got r1=%b d1=%h r0=%b want r1=1 d1=0000aaaa r0=0", m1_ready, m1_rdata, m0_ready);
    end
    s_ready = 1'b0;
    tick();
    checks++;
    if (m1_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_once got %b want 0", m1_ready);
    end
  endtask

  task automatic test_timeout();
    m0_valid = 1'b1; m0_addr = 32'h0000_0300; m0_wstrb = 4'h0;
    s_ready = 1'b0;
    tick();
    for (int k = 2; k <= 8; k++) begin
      tick();
      checks++;
      if ({s_valid, m0_ready, timeout_o} !== 3'b100) begin
        errors++;
        $display("FAIL to_wait k=%0d got %b want 100", k, {s_valid, m0_ready, timeout_o});
      end
    end
    tick();
    checks++;
    if ({m0_ready, m0_rdata, timeout_o, timeout_cnt_o} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL to_resp got r=%b d=%h t=%b c=%0d want r=1 d=deadbeef t=1 c=1",
               m0_ready, m0_rdata, timeout_o, timeout_cnt_o);
    end
    m0_valid = 1'b0;
    tick();
    checks++;
    if ({timeout_o, timeout_cnt_o} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL to_pulse got t=%b c=%0d want t=0 c=1", timeout_o, timeout_cnt_o);
    end
  endtask

  task automatic test_expiry_ack();
    m0_valid = 1'b1; s_ready = 1'b0;
    tick();
    for (int k = 2; k <= 8; k++) tick();
    checks++;
    if (m0_ready !== 1'b0) begin
      errors++;
      $display("FAIL ex_early got %b want 0", m0_ready);
    end
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    tick();
    checks++;
    if ({m0_ready, m0_rdata, timeout_o, timeout_cnt_o} !== {1'b1, 32'h0BAD_F00D, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL ex_resp got r=%b d=%h t=%b c=%0d want r=1 d=0badf00d t=0 c=1",
               m0_ready, m0_rdata, timeout_o, timeout_cnt_o);
    end
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    logic got;
    for (int n = 0; n < 300; n++) begin
      m0_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (m0_ready === 1'b1) got = 1'b1;
      end
      m0_valid = 1'b0;
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL sat_done n=%0d got no ready want ready within 20 cycles", n);
      end
      tick();
    end
    checks++;
    if (timeout_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL sat_count got %0d want 255", timeout_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    m1_valid = 1'b1; s_ready = 1'b0;
    tick();
    checks++;
    if ({s_valid, grant_o} !== 2'b11) begin
      errors++;
      $display("FAIL rm_busy got %b want 11", {s_valid, grant_o});
    end
    rst_n = 1'b0; m1_valid = 1'b0;
    tick();
    checks++;
    if ({s_valid, grant_o, m1_ready, timeout_cnt_o} !== {3'b000, 8'd0}) begin
      errors++;
      $display("FAIL rm_reset got sv=%b g=%b r1=%b c=%0d want 0 0 0 0", s_valid, grant_o, m1_ready, timeout_cnt_o);
    end
    rst_n = 1'b1; s_ready = 1'b1;
    tick();
    checks++;
    if ({m0_ready, m1_ready, s_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rm_nopulse got %b want 000", {m0_ready, m1_ready, s_valid});
    end
    s_ready = 1'b0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    tick();
    checks++;
    if ({s_valid, grant_o} !== 2'b10) begin
      errors++;
      $display("FAIL rm_regrant got %b want 10", {s_valid, grant_o});
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    test_reset();
    test_m0_read();
    test_round_robin();
    test_m1_write();
    test_timeout();
    test_expiry_ack();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion want finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/native_bus_arbiter.md
Name: native_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC's native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Master 0 is the RISC-V core; master 1 is the debug/UART program loader.
- Grants use round-robin with the grant locked for the whole transaction. One transaction is outstanding at a time.
- A timeout watchdog terminates any transaction the slave never acknowledges, so a missing slave cannot hang boot.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb is DATA_W/8)
TIMEOUT, 255, slave cycles allowed before forced termination (1..65535)
TIMEOUT_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
sys_clk_i  in  1  clock
rst_n  in  1  synchronous active-low reset
m0_valid  in  1  master 0 request, held until m0_ready
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_wstrb  in  DATA_W/8  master 0 byte strobes (0 = read)
m0_ready  out  1  master 0 completion pulse
m0_rdata  out  DATA_W  master 0 read data, valid with m0_ready
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  as for m0, master 1
s_valid  out  1  slave request
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_wstrb  out  DATA_W/8  slave strobes
s_ready  in  1  slave acknowledge
s_rdata  in  DATA_W  slave read data, sampled with s_ready
grant_o  out  1  index of the current/last granted master
timeout_o  out  1  one-cycle pulse on a timeout termination
timeout_cnt_o  out  8  saturating count of timeouts

Behaviour:
- Reset and clock
  - Reset is synchronous and active-low: one clock, sampled on the sys_clk_i rising edge while rst_n=0.
  - In reset, all outputs are 0 and state is IDLE. last_grant=1, so m0 wins the first contention.
- State machine: IDLE, BUSY, RESP.
- IDLE
  - No request: stay in IDLE.
  - One master requesting: grant it.
  - Both requesting: grant the master != last_grant.
  - On a grant, register the granted master's addr/wdata/wstrb into s_* and go to BUSY. s_valid rises the cycle after the request is sampled.
- BUSY
  - s_valid=1 and s_addr/s_wdata/s_wstrb are held stable.
  - The wait counter increments each cycle.
  - s_ready=1: capture s_rdata and go to RESP.
  - Counter reaches TIMEOUT with s_ready still 0: load TIMEOUT_DATA as the response and go to RESP. timeout_o pulses in the RESP cycle and timeout_cnt_o increments, saturating at 255.
  - s_ready=1 in the same cycle the counter reaches TIMEOUT: treat as a normal completion, no timeout.
- RESP
  - s_valid=0.
  - m<g>_ready=1 for exactly one cycle, with m<g>_rdata = captured data.
  - last_grant <= g, then return to IDLE.
- Latency
  - Request sampled at edge N → s_valid from N+1 → slave ready at edge M → master ready at M+1.
  - Minimum 3 cycles per transaction, 1 idle cycle between transactions.
- Ungranted master: ready=0 and rdata=0 at all times.
- Master drops valid while granted: ignored. The transaction completes and its ready pulse is still issued.
- Writes: the response path is identical to reads; rdata is don't-care but still driven from the capture.
- grant_o updates on entering BUSY and holds through IDLE.
- Reset asserted mid-transaction: the transaction is abandoned, no ready pulse, s_valid drops at the next edge.

Decomposition:
- Package native_bus_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - the bus request struct (addr, wdata, wstrb)
  - the TIMEOUT_DATA default constant
- One sub-module, bus_timeout_counter: counter with clear/enable and an expired flag at TIMEOUT. Everything else lives in the top module.

Test Plan:
- m0 read of 0x0000_0010; slave returns 0x1234_5678 two cycles after s_valid → m0_ready high one cycle with m0_rdata=0x1234_5678; m1_ready stays 0; grant_o=0.
- m0 and m1 requesting continuously, each completion acked immediately → grants alternate 0,1,0,1. First grant is 0 after reset. Each transaction takes exactly 3 cycles plus 1 idle cycle.
- m1 write 0x2000_0004, wstrb=4'hF, wdata=0x0000_0041 → s_addr/s_wdata/s_wstrb match and stay stable until s_ready; m1_ready pulses once.
- TIMEOUT=8, slave never ready → after 8 BUSY cycles, m0_ready=1 with rdata=0xDEAD_BEEF, timeout_o pulses, timeout_cnt_o=1. 300 timeouts → timeout_cnt_o saturates at 255.
- s_ready arrives on the expiry cycle → normal rdata returned, timeout_o=0, count unchanged.
- rst_n=0 for one cycle during BUSY → no ready pulse, s_valid=0 on the next edge, grant_o=0. The next contention is granted to m0.
